umidade_classificador: RTL
==========================

Name: umidade_classificador

Overview:
- Upstream stage of the humidity display path. It turns raw humidity sensor samples into the 2-bit humidity level U (0 = dry .. 3 = saturated) that the display/indicator stage consumes.
- Averages a fixed window of samples, classifies the average against three thresholds with hysteresis, and flags a silent sensor through a watchdog.

Parameters:
- W, 8, width of a raw sample
- N_LOG2, 2, log2 of the averaging window (window = 4 samples)
- LIM1, 64, threshold between level 0 and level 1
- LIM2, 128, threshold between level 1 and level 2
- LIM3, 192, threshold between level 2 and level 3
- HIST, 8, hysteresis half-band. Constraint: LIM1 >= HIST and LIM3 + HIST <= 2^W - 1.
- TIMEOUT, 1000, cycles without a sample before the sensor error is raised

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- amostra_valida  input  1  one-cycle strobe: amostra is valid this cycle
- amostra  input  W  raw sensor sample
- U  output  2  current humidity level, registered; feeds the display stage
- U_valido  output  1  one-cycle pulse: a window closed and U was re-evaluated
- mudou  output  1  one-cycle pulse: U changed value on this evaluation
- erro_sensor  output  1  sticky flag: watchdog expired

Behaviour:
- Reset (asynchronous, active-high): U=0, U_valido=0, mudou=0, erro_sensor=0. Accumulator, sample counter and watchdog counter are all 0.
- Accumulator is W+N_LOG2 bits wide and never overflows.
- Sample accepted on a rising edge with amostra_valida=1:
  - Not the last sample of the window: acc += amostra, cnt += 1.
  - Last sample (cnt = 2^N_LOG2 - 1):
    - media = (acc + amostra) >> N_LOG2, truncating.
    - U takes its new value on this same edge.
    - acc and cnt return to 0.
    - U_valido = 1 for the following cycle.
    - mudou = 1 for that same cycle only if U changed.
- Classification, with the hysteresis band on each threshold LIMk:
  - sobe = number of k in {1,2,3} with media >= LIMk + HIST.
  - desce = number of k with media >= LIMk - HIST.
  - If sobe > U: U <= sobe (multi-level jumps allowed).
  - Else if desce < U: U <= desce.
  - Else U holds.
- Level FSM: states NIVEL0..NIVEL3, encoded as U. Transitions occur only at window close.
- U_valido and mudou are 0 in every cycle not following a window close.
- Watchdog:
  - wd counts cycles since the last accepted sample and clears on every accepted sample.
  - When wd reaches TIMEOUT-1 with no sample this cycle: erro_sensor <= 1, the partial window is discarded (acc=0, cnt=0), wd <= 0, U holds.
  - If a sample arrives in the same cycle the watchdog would expire, the sample wins: it is accepted and no error is raised.
  - erro_sensor clears only at the next complete window close or at reset.
- amostra_valida held high for consecutive cycles gives one sample per cycle; there are no back-to-back restrictions.
- Reset asserted mid-window discards the partial window; the first post-reset window starts at cnt=0.

Optional Feature:
- Macro UMIDADE_HIST_EN.
- Defined: hysteresis as specified above.
- Undefined: HIST is treated as 0, so sobe = desce and U = number of thresholds with media >= LIMk. Pure threshold classification; the rest of the behaviour is unchanged.

Test Plan:
- Reset, then 4 samples of 200 → U=3 on the 4th sample edge, U_valido and mudou pulse one cycle each.
- From U=3, samples 190,190,190,190 → media 190: with UMIDADE_HIST_EN U stays 3 (U_valido=1, mudou=0); without the macro U=2, mudou=1.
- From U=3, samples 100,100,100,104 → media 101 → U=1 in one step, mudou=1.
- 2 samples of 250, then 1000 idle cycles → erro_sensor=1, partial discarded, U unchanged. Next 4 samples of 0 → U=0, erro_sensor=0.
- Sample arriving on watchdog cycle 999 → erro_sensor stays 0, cnt increments.
- Reset asserted after 3 samples of 255 → all outputs 0 immediately. The next 4 samples of 70 → U=0 with hysteresis (70 < 72); U=1 without the macro.

Source files
------------

// File: rtl/umidade_classificador.sv
// umidade_classificador
// Turns raw humidity samples into a 2-bit humidity level U (0 = dry .. 3 = saturated).
// It averages a window of 2^N_LOG2 samples and classifies the average against
// LIM1/LIM2/LIM3. A watchdog raises a sticky erro_sensor flag when the sensor goes silent.
// Optional feature: define UMIDADE_HIST_EN to enable a +/-HIST hysteresis band on each
// threshold. Without it the block does pure threshold classification.

module umidade_classificador #(
   parameter int W       = 8,
   parameter int N_LOG2  = 2,
   parameter int LIM1    = 64,
   parameter int LIM2    = 128,
   parameter int LIM3    = 192,
   parameter int HIST    = 8,
   parameter int TIMEOUT = 1000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         amostra_valida,
   input  logic [W-1:0] amostra,
   output logic [1:0]   U,
   output logic         U_valido,
   output logic         mudou,
   output logic         erro_sensor
);

   // Accumulator width: W+N_LOG2 bits holds the sum of a full window without overflow
   localparam int AW = W + N_LOG2;

`ifdef UMIDADE_HIST_EN
   localparam int HIST_EF = HIST;
`else
   // Hysteresis disabled: the band collapses to zero, so the up and down thresholds coincide
   localparam int HIST_EF = HIST * 0;
`endif

   // Up thresholds (LIMk + HIST) and down thresholds (LIMk - HIST), widened to the accumulator width
   localparam logic [AW-1:0] SOBE1  = AW'(LIM1 + HIST_EF);
   localparam logic [AW-1:0] SOBE2  = AW'(LIM2 + HIST_EF);
   localparam logic [AW-1:0] SOBE3  = AW'(LIM3 + HIST_EF);
   localparam logic [AW-1:0] DESCE1 = AW'(LIM1 - HIST_EF);
   localparam logic [AW-1:0] DESCE2 = AW'(LIM2 - HIST_EF);
   localparam logic [AW-1:0] DESCE3 = AW'(LIM3 - HIST_EF);

   localparam logic [N_LOG2-1:0] CNT_MAX = '1;
   localparam logic [N_LOG2-1:0] CNT_ONE = N_LOG2'(1);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

   // Level FSM states; the encoding is the level value driven on U
   localparam logic [1:0] NIVEL0 = 2'd0;
   localparam logic [1:0] NIVEL1 = 2'd1;
   localparam logic [1:0] NIVEL2 = 2'd2;
   localparam logic [1:0] NIVEL3 = 2'd3;

   logic [AW-1:0]     acc;
   logic [N_LOG2-1:0] cnt;
   logic [WD_W-1:0]   wd;
   logic [1:0]        nivel;

   logic [AW-1:0]     soma;
   logic [AW-1:0]     media;
   logic [1:0]        sobe;
   logic [1:0]        desce;
   logic [1:0]        nivel_prox;
   logic              fecha_janela;
   logic              expira;

   // Sum including the incoming sample, and the truncated window average
   always_comb begin
      soma  = acc + {{N_LOG2{1'b0}}, amostra};
      media = soma >> N_LOG2;
   end

   // Count the thresholds crossed upward and downward, then pick the next level
   always_comb begin
      sobe  = {1'b0, media >= SOBE1} + {1'b0, media >= SOBE2} + {1'b0, media >= SOBE3};
      desce = {1'b0, media >= DESCE1} + {1'b0, media >= DESCE2} + {1'b0, media >= DESCE3};
      nivel_prox = nivel;
      if (sobe > nivel) begin
         nivel_prox = sobe;
      end else if (desce < nivel) begin
         nivel_prox = desce;
      end
      case (nivel_prox)
         NIVEL0:  nivel_prox = NIVEL0;
         NIVEL1:  nivel_prox = NIVEL1;
         NIVEL2:  nivel_prox = NIVEL2;
         default: nivel_prox = NIVEL3;
      endcase
   end

   // A window closes on its last sample. The watchdog expires only when no sample arrives on its last cycle
   always_comb begin
      fecha_janela = amostra_valida && (cnt == CNT_MAX);
      expira       = !amostra_valida && (wd == WD_MAX);
   end

   // Accumulator, window counter and watchdog. An expiry drops the partial window
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
         cnt <= '0;
         wd  <= '0;
      end else if (amostra_valida) begin
         wd <= '0;
         if (fecha_janela) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= soma;
            cnt <= cnt + CNT_ONE;
         end
      end else if (expira) begin
         acc <= '0;
         cnt <= '0;
         wd  <= '0;
      end else begin
         wd <= wd + WD_ONE;
      end
   end

   // Level FSM: it moves only at window close. The valid/changed pulses last one cycle after the close
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nivel    <= NIVEL0;
         U_valido <= 1'b0;
         mudou    <= 1'b0;
      end else begin
         U_valido <= fecha_janela;
         mudou    <= fecha_janela && (nivel_prox != nivel);
         if (fecha_janela) begin
            nivel <= nivel_prox;
         end
      end
   end

   // Sticky sensor error: the watchdog sets it, and only a complete window clears it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         erro_sensor <= 1'b0;
      end else if (fecha_janela) begin
         erro_sensor <= 1'b0;
      end else if (expira) begin
         erro_sensor <= 1'b1;
      end
   end

   assign U = nivel;

endmodule
